axis_demux_1_2: RTL and testbench

//  1-to-2 AXI-stream demultiplexer (router); the counterpart of the 2:1 stream mux.

---
 rtl/axis_demux_1_2.sv | 123 ++++++++++++
 tb/tb_axis_demux_1_2.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/axis_demux_1_2.sv
// 1-to-2 AXI-stream demultiplexer. The route is locked per packet, and each output
// has a main+skid register pair for registered outputs at full throughput.
module axis_demux_1_2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] m_data_1,
  output logic                  m_valid_1,
  input  logic                  m_ready_1,
  output logic                  m_last_1,
  output logic [DATA_WIDTH-1:0] m_data_2,
  output logic                  m_valid_2,
  input  logic                  m_ready_2,
  output logic                  m_last_2
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t                state, state_next;
  logic                  route_q, route_next;
  logic                  route;
  logic                  accept;
  logic [1:0]            m_ready;
  logic [1:0]            main_valid;
  logic [1:0]            skid_valid;
  logic [1:0]            main_last;
  logic [DATA_WIDTH-1:0] main_data [2];

  assign m_ready = {m_ready_2, m_ready_1};

  always_comb begin
    route   = (state == IDLE) ? sel : route_q;
    s_ready = !reset && !skid_valid[route];
    accept  = s_valid && s_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      route_q <= 1'b0;
    end else begin
      state   <= state_next;
      route_q <= route_next;
    end
  end

  always_comb begin
    state_next = state;
    route_next = route_q;
    case (state)
      IDLE: begin
        if (accept && !s_last) begin
          state_next = PKT;
          route_next = sel;
        end
      end
      PKT: begin
        if (accept && s_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar g = 0; g < 2; g++) begin : g_out
    logic                  take, drain;
    logic                  mv, sv, ml, sl;
    logic [DATA_WIDTH-1:0] md, sd;

    always_comb begin
      take  = accept && (route == 1'(g));
      drain = mv && m_ready[g];
    end

    // A routed beat only arrives while skid is empty, so take and skid-refill never collide.
    always_ff @(posedge clk) begin
      if (reset) begin
        mv <= 1'b0;
        sv <= 1'b0;
        ml <= 1'b0;
        sl <= 1'b0;
        md <= '0;
        sd <= '0;
      end else if (take) begin
        if (!mv || m_ready[g]) begin
          mv <= 1'b1;
          md <= s_data;
          ml <= s_last;
        end else begin
          sv <= 1'b1;
          sd <= s_data;
          sl <= s_last;
        end
      end else if (drain) begin
        if (sv) begin
          md <= sd;
          ml <= sl;
          sv <= 1'b0;
        end else begin
          mv <= 1'b0;
        end
      end
    end

    assign main_valid[g] = mv;
    assign skid_valid[g] = sv;
    assign main_last[g]  = ml;
    assign main_data[g]  = md;
  end

  assign m_valid_1 = main_valid[0];
  assign m_last_1  = main_last[0];
  assign m_data_1  = main_data[0];
  assign m_valid_2 = main_valid[1];
  assign m_last_2  = main_last[1];
  assign m_data_2  = main_data[1];

endmodule

// File: tb/tb_axis_demux_1_2.sv
// Randomized scoreboard bench for axis_demux_1_2: per-output expected-beat queues
// and a packet-level routing model.
module tb_axis_demux_1_2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          sel;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic [DW-1:0] m_data_1, m_data_2;
  logic          m_valid_1, m_valid_2;
  logic          m_ready_1, m_ready_2;
  logic          m_last_1, m_last_2;

  axis_demux_1_2 #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .sel(sel),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .m_data_1(m_data_1), .m_valid_1(m_valid_1), .m_ready_1(m_ready_1), .m_last_1(m_last_1),
    .m_data_2(m_data_2), .m_valid_2(m_valid_2), .m_ready_2(m_ready_2), .m_last_2(m_last_2)
  );

  always #5 clk = ~clk;

  logic [DW:0] q1[$];
  logic [DW:0] q2[$];
  int          checks = 0;
  int          passes = 0;
  bit          in_pkt = 1'b0;
  bit          lock_route = 1'b0;
  bit          post_rst = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor/scoreboard: all sampling on the falling edge, between driver updates.
  always @(negedge clk) begin
    bit r;
    if (reset) begin
      check("s_ready_in_reset", 32'(s_ready), 32'd0);
      q1.delete();
      q2.delete();
      in_pkt   = 1'b0;
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        check("rst_out_1", {22'd0, m_valid_1, m_last_1, m_data_1}, 32'd0);
        check("rst_out_2", {22'd0, m_valid_2, m_last_2, m_data_2}, 32'd0);
        post_rst = 1'b0;
      end
      r = in_pkt ? lock_route : sel;
      check("s_ready", 32'(s_ready), 32'((r ? q2.size() : q1.size()) < 2));
      check("m_valid_1", 32'(m_valid_1), 32'(q1.size() != 0));
      check("m_valid_2", 32'(m_valid_2), 32'(q2.size() != 0));
      if (m_valid_1 && q1.size() != 0) check("m_beat_1", 32'({m_last_1, m_data_1}), 32'(q1[0]));
      if (m_valid_2 && q2.size() != 0) check("m_beat_2", 32'({m_last_2, m_data_2}), 32'(q2[0]));
      if (m_valid_1 && m_ready_1 && q1.size() != 0) void'(q1.pop_front());
      if (m_valid_2 && m_ready_2 && q2.size() != 0) void'(q2.pop_front());
      if (s_valid && s_ready) begin
        if (r) q2.push_back({s_last, s_data});
        else   q1.push_back({s_last, s_data});
        if (s_last) in_pkt = 1'b0;
        else if (!in_pkt) begin
          in_pkt     = 1'b1;
          lock_route = sel;
        end
      end
    end
  end

  int p1s[6] = '{100, 50, 0, 100, 20, 70};
  int p2s[6] = '{100, 50, 100, 0, 80, 30};

  initial begin
    int pkt_left;
    int waited;
    bit acc;
    reset     = 1'b1;
    sel       = 1'b0;
    s_data    = '0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    m_ready_1 = 1'b0;
    m_ready_2 = 1'b0;
    pkt_left  = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int ph = 0; ph < 6; ph++) begin
      if (ph == 3) begin
        // Abort mid-packet, likely with output 1 backed up from the previous phase.
        s_valid = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        pkt_left = 0;
      end
      for (int b = 0; b < 40; b++) begin
        if (pkt_left == 0) pkt_left = int'($urandom_range(4, 1));
        if ($urandom_range(99) < 20) begin
          s_valid   = 1'b0;
          sel       = 1'($urandom);
          m_ready_1 = $urandom_range(99) < p1s[ph];
          m_ready_2 = $urandom_range(99) < p2s[ph];
          @(posedge clk);
          #1;
        end
        s_valid = 1'b1;
        s_data  = DW'($urandom);
        s_last  = (pkt_left == 1);
        waited  = 0;
        acc     = 1'b0;
        while (!acc) begin
          sel       = 1'($urandom);
          m_ready_1 = ($urandom_range(99) < p1s[ph]) || (waited > 20);
          m_ready_2 = ($urandom_range(99) < p2s[ph]) || (waited > 20);
          @(negedge clk);
          acc = s_valid && s_ready;
          @(posedge clk);
          #1;
          waited++;
          if (!acc && waited > 200) begin
            checks++;
            $display("FAIL accept_timeout: beat not accepted after %0d cycles, required acceptance", waited);
            break;
          end
        end
        pkt_left--;
      end
    end

    s_valid   = 1'b0;
    m_ready_1 = 1'b1;
    m_ready_2 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("drain_q1", 32'(q1.size()), 32'd0);
    check("drain_q2", 32'(q2.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
